// File: rtl/tx_flow_controller_if.sv
// tx_flow_controller_if: configuration, status and flag bundle between the
// transmit-layer sequencer and the datapath it supervises (VC0/VC1 FIFOs,
// routing arbiter, D0/D1 FIFOs).
interface tx_flow_controller_if #(
  parameter int THR_WIDTH = 3
);
  logic                 init;
  logic [THR_WIDTH-1:0] thr_af_in;
  logic [THR_WIDTH-1:0] thr_ae_in;
  logic [3:0]           empty_vec;
  logic [3:0]           error_vec;
  logic [THR_WIDTH-1:0] thr_af_out;
  logic [THR_WIDTH-1:0] thr_ae_out;
  logic [2:0]           state;
  logic                 idle_out;
  logic                 active_out;
  logic                 error_out;
  logic                 cfg_err;
  logic [3:0]           err_src;
  logic [15:0]          active_cycles;

  // Controller side
  modport slave (
    input  init, thr_af_in, thr_ae_in, empty_vec, error_vec,
    output thr_af_out, thr_ae_out, state, idle_out, active_out, error_out,
           cfg_err, err_src, active_cycles
  );

  // Configuration / datapath side
  modport master (
    output init, thr_af_in, thr_ae_in, empty_vec, error_vec,
    input  thr_af_out, thr_ae_out, state, idle_out, active_out, error_out,
           cfg_err, err_src, active_cycles
  );
endinterface

// File: rtl/tx_flow_controller.sv
// tx_flow_controller: operating state machine (RESET/INIT/IDLE/ACTIVE/ERROR)
// for the transmit-layer datapath. Latches and validates the FIFO almost-full
// and almost-empty thresholds, reports activity and captures the first FIFO
// error. Optional feature macro: TX_ACTIVE_CNT_EN builds the saturating
// ACTIVE-cycle counter; when undefined active_cycles is tied to zero.
module tx_flow_controller #(
  parameter int FIFO_DEPTH = 8,
  parameter int THR_WIDTH  = 3,
  parameter int IDLE_HOLD  = 2
) (
  input  logic                  clk,
  input  logic                  reset_L,
  tx_flow_controller_if.slave   bus
);

  localparam int HOLD_W = (IDLE_HOLD > 1) ? $clog2(IDLE_HOLD) : 1;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [HOLD_W-1:0]    r_hold;
  logic [HOLD_W-1:0]    w_hold_nxt;
  logic [THR_WIDTH-1:0] r_thr_af;
  logic [THR_WIDTH-1:0] r_thr_ae;
  logic                 r_cfg_err;
  logic [3:0]           r_err_src;
  logic                 r_idle;
  logic                 r_active;
  logic                 r_error;
  logic                 w_thr_valid;
  logic                 w_all_empty;
  logic                 w_any_err;

  // Thresholds are usable when almost-full lies inside the FIFO and
  // almost-empty sits strictly below it.
  function automatic logic thr_ok(input logic [THR_WIDTH-1:0] af,
                                  input logic [THR_WIDTH-1:0] ae);
    return (32'(af) >= 32'd1) && (32'(af) <= 32'(FIFO_DEPTH - 1)) && (ae < af);
  endfunction

  assign w_thr_valid = thr_ok(bus.thr_af_in, bus.thr_ae_in);
  assign w_all_empty = (bus.empty_vec == 4'hF);
  assign w_any_err   = |bus.error_vec;

  // State and idle-hold counter registers
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= ST_RESET;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // Next state: error beats init beats the per-state rule
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = '0;
    case (r_state)
      ST_RESET: w_state_nxt = ST_INIT;
      ST_INIT: begin
        if (w_any_err)        w_state_nxt = ST_ERROR;
        else if (bus.init)    w_state_nxt = ST_INIT;
        else if (w_thr_valid) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (w_any_err)         w_state_nxt = ST_ERROR;
        else if (bus.init)     w_state_nxt = ST_INIT;
        else if (!w_all_empty) w_state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (w_any_err)       w_state_nxt = ST_ERROR;
        else if (bus.init)   w_state_nxt = ST_INIT;
        else if (w_all_empty) begin
          // The drain must persist IDLE_HOLD edges before going quiet
          if (r_hold == HOLD_W'(IDLE_HOLD - 1)) w_state_nxt = ST_IDLE;
          else                                  w_hold_nxt  = r_hold + 1'b1;
        end
      end
      ST_ERROR: w_state_nxt = ST_ERROR;
      default:  w_state_nxt = ST_RESET;
    endcase
  end

  // Configuration capture in INIT, first-error capture, registered flags
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_thr_af  <= THR_WIDTH'(FIFO_DEPTH - 2);
      r_thr_ae  <= THR_WIDTH'(1);
      r_cfg_err <= 1'b0;
      r_err_src <= 4'h0;
      r_idle    <= 1'b0;
      r_active  <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      if (r_state == ST_INIT) begin
        r_thr_af  <= bus.thr_af_in;
        r_thr_ae  <= bus.thr_ae_in;
        r_cfg_err <= ~w_thr_valid;
      end
      if ((w_state_nxt == ST_ERROR) && (r_state != ST_ERROR))
        r_err_src <= bus.error_vec;
      r_idle   <= (w_state_nxt == ST_IDLE);
      r_active <= (w_state_nxt == ST_ACTIVE);
      r_error  <= (w_state_nxt == ST_ERROR);
    end
  end

`ifdef TX_ACTIVE_CNT_EN
  logic [15:0] r_active_cnt;

  // Saturating count of ACTIVE cycles, restarted whenever INIT is entered
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)
      r_active_cnt <= 16'h0000;
    else if (w_state_nxt == ST_INIT)
      r_active_cnt <= 16'h0000;
    else if ((r_state == ST_ACTIVE) && (r_active_cnt != 16'hFFFF))
      r_active_cnt <= r_active_cnt + 16'd1;
  end

  assign bus.active_cycles = r_active_cnt;
`else
  assign bus.active_cycles = 16'h0000;
`endif

  assign bus.state      = r_state;
  assign bus.thr_af_out = r_thr_af;
  assign bus.thr_ae_out = r_thr_ae;
  assign bus.cfg_err    = r_cfg_err;
  assign bus.err_src    = r_err_src;
  assign bus.idle_out   = r_idle;
  assign bus.active_out = r_active;
  assign bus.error_out  = r_error;

endmodule

// File: tb/tb_tx_flow_controller.sv
// tb_tx_flow_controller: directed stimulus with a behavioural reference model
// compared on every falling edge, plus literal expectations at key points.
module tb_tx_flow_controller;

  localparam int FIFO_DEPTH = 8;
  localparam int THR_WIDTH  = 3;
  localparam int IDLE_HOLD  = 2;
`ifdef TX_ACTIVE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_L;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   cmp_en   = 1'b0;

  tx_flow_controller_if #(.THR_WIDTH(THR_WIDTH)) bus();

  tx_flow_controller #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .THR_WIDTH (THR_WIDTH),
    .IDLE_HOLD (IDLE_HOLD)
  ) dut (
    .clk    (clk),
    .reset_L(reset_L),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // States are numbered as they appear on the state output.
  int         m_state;
  logic [2:0] m_af, m_ae;
  logic       m_cfg_err;
  logic [3:0] m_src;
  int         m_run;   // consecutive all-empty edges seen while ACTIVE
  int         m_cnt;

  function automatic bit cfg_ok(input logic [2:0] af, input logic [2:0] ae);
    return (af >= 1) && (int'(af) <= FIFO_DEPTH - 1) && (ae < af);
  endfunction

  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      m_state <= 0; m_af <= 3'(FIFO_DEPTH - 2); m_ae <= 3'd1;
      m_cfg_err <= 1'b0; m_src <= 4'h0; m_run <= 0; m_cnt <= 0;
    end else begin
      if (CNT_EN && m_state == 3 && m_cnt < 65535) m_cnt <= m_cnt + 1;
      if (m_state == 1) begin
        m_af <= bus.thr_af_in; m_ae <= bus.thr_ae_in;
        m_cfg_err <= !cfg_ok(bus.thr_af_in, bus.thr_ae_in);
      end
      if (m_state == 0) begin
        m_state <= 1; m_cnt <= 0;
      end else if (m_state != 4) begin
        if (bus.error_vec != 4'h0) begin
          m_state <= 4; m_src <= bus.error_vec; m_run <= 0;
        end else if (bus.init) begin
          m_state <= 1; m_run <= 0; m_cnt <= 0;
        end else if (m_state == 1) begin
          if (cfg_ok(bus.thr_af_in, bus.thr_ae_in)) m_state <= 2;
        end else if (m_state == 2) begin
          m_run <= 0;
          if (bus.empty_vec != 4'hF) m_state <= 3;
        end else begin
          if (bus.empty_vec == 4'hF) begin
            if (m_run + 1 >= IDLE_HOLD) begin m_state <= 2; m_run <= 0; end
            else m_run <= m_run + 1;
          end else m_run <= 0;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("state",    bus.state,         m_state);
      check("thr_af",   bus.thr_af_out,    m_af);
      check("thr_ae",   bus.thr_ae_out,    m_ae);
      check("cfg_err",  bus.cfg_err,       m_cfg_err);
      check("err_src",  bus.err_src,       m_src);
      check("idle",     bus.idle_out,      m_state == 2);
      check("active",   bus.active_out,    m_state == 3);
      check("error",    bus.error_out,     m_state == 4);
      check("act_cyc",  bus.active_cycles, m_cnt);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset_L = 1'b0;
    bus.init = 1'b0; bus.thr_af_in = 3'd6; bus.thr_ae_in = 3'd1;
    bus.empty_vec = 4'hF; bus.error_vec = 4'h0;
    cmp_en = 1'b1;

    tick();
    check("L_rst_state", bus.state, 0);
    check("L_rst_af",    bus.thr_af_out, 6);
    check("L_rst_ae",    bus.thr_ae_out, 1);
    tick();
    reset_L = 1'b1;
    tick();
    check("L_init_state", bus.state, 1);
    tick();
    check("L_idle_state", bus.state, 2);
    check("L_idle_flag",  bus.idle_out, 1);
    check("L_idle_af",    bus.thr_af_out, 6);
    check("L_idle_cfg",   bus.cfg_err, 0);

    // bad thresholds keep the block in INIT
    bus.init = 1'b1; bus.thr_af_in = 3'd0; bus.thr_ae_in = 3'd2;
    tick();
    check("L_reinit_state", bus.state, 1);
    tick();
    bus.init = 1'b0;
    tick();
    check("L_bad_state", bus.state, 1);
    check("L_bad_cfg",   bus.cfg_err, 1);
    check("L_bad_af",    bus.thr_af_out, 0);
    bus.thr_af_in = 3'd7; bus.thr_ae_in = 3'd7;
    tick();
    check("L_eq_state", bus.state, 1);
    check("L_eq_cfg",   bus.cfg_err, 1);
    bus.thr_af_in = 3'd5; bus.thr_ae_in = 3'd2;
    tick();
    check("L_ok_state", bus.state, 2);
    check("L_ok_af",    bus.thr_af_out, 5);
    check("L_ok_ae",    bus.thr_ae_out, 2);
    check("L_ok_cfg",   bus.cfg_err, 0);

    // IDLE -> ACTIVE and the idle-hold drain with a restart
    bus.empty_vec = 4'hE;
    tick();
    check("L_act_state", bus.state, 3);
    check("L_act_flag",  bus.active_out, 1);
    bus.empty_vec = 4'hF;
    tick();
    check("L_hold1_state", bus.state, 3);
    bus.empty_vec = 4'hE;
    tick();
    check("L_pulse_state", bus.state, 3);
    bus.empty_vec = 4'hF;
    tick();
    check("L_restart_state", bus.state, 3);
    tick();
    check("L_drain_state", bus.state, 2);

    // ACTIVE-cycle counter
    bus.init = 1'b1;
    tick();
    check("L_cnt_clr0", bus.active_cycles, 0);
    bus.init = 1'b0;
    tick();
    bus.empty_vec = 4'hE;
    tick();
    repeat (10) tick();
    check("L_cnt10", bus.active_cycles, CNT_EN ? 10 : 0);
    bus.init = 1'b1;
    tick();
    check("L_cnt_clr1",  bus.active_cycles, 0);
    check("L_cnt_state", bus.state, 1);
    bus.init = 1'b0;
    tick();

    // error with simultaneous init while ACTIVE
    tick();
    bus.error_vec = 4'b0100; bus.init = 1'b1;
    tick();
    check("L_err_state", bus.state, 4);
    check("L_err_src",   bus.err_src, 4'b0100);
    check("L_err_flag",  bus.error_out, 1);
    check("L_err_act",   bus.active_out, 0);
    bus.error_vec = 4'b0001;
    tick();
    check("L_err_src_hold", bus.err_src, 4'b0100);
    bus.error_vec = 4'h0; bus.thr_af_in = 3'd3; bus.thr_ae_in = 3'd1;
    tick();
    tick();
    check("L_err_sticky", bus.state, 4);
    check("L_err_frozen", bus.thr_af_out, 5);

    // reconfigure, go ACTIVE, then reset between edges
    reset_L = 1'b0; bus.init = 1'b0;
    tick();
    check("L_rst2_src", bus.err_src, 0);
    bus.thr_af_in = 3'd4; bus.thr_ae_in = 3'd3;
    reset_L = 1'b1;
    tick();
    tick();
    check("L_cfg2_af", bus.thr_af_out, 4);
    check("L_cfg2_ae", bus.thr_ae_out, 3);
    bus.empty_vec = 4'hE;
    tick();
    check("L_act2_state", bus.state, 3);
    @(posedge clk);
    #2;
    reset_L = 1'b0;
    #1;
    check("L_async_state", bus.state, 0);
    check("L_async_act",   bus.active_out, 0);
    check("L_async_af",    bus.thr_af_out, 6);
    check("L_async_ae",    bus.thr_ae_out, 1);
    check("L_async_cnt",   bus.active_cycles, 0);
    tick();
    reset_L = 1'b1;
    tick();

    // error pulse while in INIT
    bus.init = 1'b1; bus.error_vec = 4'b1000;
    tick();
    check("L_initerr_state", bus.state, 4);
    check("L_initerr_src",   bus.err_src, 4'b1000);
    bus.error_vec = 4'h0; bus.init = 1'b0;
    tick();
    reset_L = 1'b0;
    tick();
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tx_flow_controller.md
Name: tx_flow_controller

Overview:
- Top-level sequencer for the transmit-layer datapath of VC0/VC1 FIFOs, the routing arbiter and the D0/D1 FIFOs.
- Owns the operating state machine: RESET, INIT, IDLE, ACTIVE, ERROR.
- Latches and validates the almost-full/almost-empty thresholds that configure all four FIFOs.
- Reports datapath activity and latches the first FIFO error for debug.

Parameters:
FIFO_DEPTH, 8, depth of every datapath FIFO (entries)
THR_WIDTH, 3, width of threshold fields
IDLE_HOLD, 2, consecutive all-empty cycles required in ACTIVE before returning to IDLE

Ports:
clk  input  1  clock, all state on rising edge
reset_L  input  1  asynchronous active-low reset
init  input  1  configuration request; thresholds sampled while high
thr_af_in  input  THR_WIDTH  requested almost-full threshold
thr_ae_in  input  THR_WIDTH  requested almost-empty threshold
empty_vec  input  4  {D1,D0,VC1,VC0} FIFO empty flags
error_vec  input  4  {D1,D0,VC1,VC0} FIFO error flags
thr_af_out  output  THR_WIDTH  active almost-full threshold to all FIFOs
thr_ae_out  output  THR_WIDTH  active almost-empty threshold to all FIFOs
state  output  3  RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4
idle_out  output  1  high while state==IDLE
active_out  output  1  high while state==ACTIVE
error_out  output  1  high while state==ERROR
cfg_err  output  1  last sampled thresholds invalid
err_src  output  4  error_vec captured on entry to ERROR
active_cycles  output  16  cycles spent in ACTIVE (see optional feature)

Behaviour:
- Reset: reset_L low forces state=RESET asynchronously. All outputs go to 0 and the hold counter clears.
  - Exception: thr_af_out resets to FIFO_DEPTH-2 and thr_ae_out resets to 1.
- All outputs are registered. Flag outputs decode the registered state, so they change in the same cycle as state.
- Transition priority, evaluated every cycle from INIT, IDLE and ACTIVE: error (|error_vec) > init > state-specific rule.
- RESET: first clock edge with reset_L high goes to INIT unconditionally.
- INIT:
  - Every cycle, thr_af_out<=thr_af_in and thr_ae_out<=thr_ae_in.
  - cfg_err<=1 unless 1<=thr_af_in<=FIFO_DEPTH-1 and thr_ae_in<thr_af_in.
  - Leave to IDLE when init==0 and the currently sampled thresholds are valid.
  - If init==0 and thresholds are invalid, stay in INIT with cfg_err=1.
  - The thresholds that are sampled on the exit cycle are the ones held.
- IDLE:
  - init -> INIT.
  - Any bit of empty_vec low -> ACTIVE. The hold counter clears.
  - Otherwise stay in IDLE.
- ACTIVE:
  - init -> INIT.
  - If empty_vec==4'hF, the hold counter increments. When it reaches IDLE_HOLD-1 with all empty, go to IDLE.
  - Any non-empty cycle clears the hold counter.
  - With IDLE_HOLD=2, the datapath must be all-empty on 2 consecutive edges before returning to IDLE.
- ERROR:
  - Sticky. Only reset_L exits.
  - err_src<=error_vec on the entry edge and is held; later errors do not overwrite it.
  - init is ignored.
  - Thresholds are frozen.
- Thresholds are held constant outside INIT. thr_*_out changes only in INIT.
- Simultaneous error and init in IDLE/ACTIVE: go to ERROR.
- Error pulse in INIT also goes to ERROR.
- Reset asserted mid-ACTIVE: immediate asynchronous return to RESET. The thresholds revert to their defaults, so configuration is lost.

Optional Feature:
- Macro: TX_ACTIVE_CNT_EN.
- Defined:
  - active_cycles is a 16-bit counter that increments each cycle state==ACTIVE.
  - Saturates at 16'hFFFF.
  - Cleared on entry to INIT and by reset. Held in IDLE/ERROR.
- Not defined: active_cycles is tied to 16'h0000 and no counter logic is built.

Test Plan:
- Reset release with init=0, thr_af_in=6, thr_ae_in=1 -> state: RESET, then INIT, then IDLE. thr_af_out=6, thr_ae_out=1, cfg_err=0.
- In INIT, drive thr_af_in=0, thr_ae_in=2, then drop init -> stay INIT with cfg_err=1. Change to 5/2 -> IDLE on the next edge with thr_af_out=5.
- In IDLE, empty_vec=4'hE for 1 cycle, then 4'hF -> ACTIVE.
  - First all-empty edge: counter reaches 1 and state stays ACTIVE.
  - Second all-empty edge: IDLE.
  - A 4'hE pulse between the two all-empty cycles restarts the count.
- In ACTIVE, pulse error_vec=4'b0100 (D0) together with init=1 -> ERROR, err_src=4'b0100, error_out=1.
  - A later error_vec=4'b0001 leaves err_src unchanged.
  - init ignored until reset.
- Assert reset_L low mid-ACTIVE, asynchronously between clock edges -> state=0, outputs cleared, thr_af_out=FIFO_DEPTH-2=6, thr_ae_out=1 immediately.
- With TX_ACTIVE_CNT_EN: 10 cycles in ACTIVE -> active_cycles=10. Re-entering INIT -> 0.
- Without TX_ACTIVE_CNT_EN: active_cycles stays 0.
